// File: rtl/fivesons_pkg.sv
// Shared encodings for the board painter: cell status, game outcome,
// palette and FSM states.
package fivesons_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_BG_FILL   = 3'd1,
        ST_CELL_SCAN = 3'd2,
        ST_CELL_FILL = 3'd3,
        ST_PTR_DRAW  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam logic [1:0] CELL_NONE  = 2'd0;
    localparam logic [1:0] CELL_BLACK = 2'd1;
    localparam logic [1:0] CELL_BLUE  = 2'd2;
    localparam logic [1:0] CELL_WIN   = 2'd3;

    localparam logic [1:0] WIN_GAMING = 2'd0;
    localparam logic [1:0] WIN_EQUAL  = 2'd1;
    localparam logic [1:0] WIN_BLACK  = 2'd2;
    localparam logic [1:0] WIN_BLUE   = 2'd3;

    localparam logic [2:0] COL_BG     = 3'b001;
    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_BLUE   = 3'b010;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_PTR    = 3'b111;

    // Win cells only light up once someone has actually won.
    function automatic logic [2:0] cell_color(input logic [1:0] status,
                                              input logic [1:0] win);
        case (status)
            CELL_BLUE: return COL_BLUE;
            CELL_WIN:  return (win == WIN_BLACK || win == WIN_BLUE) ? COL_YELLOW : COL_BLACK;
            default:   return COL_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/board_painter_if.sv
// Frame handshake and video-memory write port of the board painter.
interface board_painter_if #(
    parameter int ADDR_BITS  = 14,
    parameter int COLOR_BITS = 3
);
    logic                  in_cont_signal;
    logic                  out_cont_signal;
    logic                  next_out_cont_signal;
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [COLOR_BITS-1:0] mem_data;
    logic                  mem_wren;

    modport master (
        input  in_cont_signal, next_out_cont_signal,
        output out_cont_signal, mem_addr, mem_data, mem_wren
    );

    modport slave (
        output in_cont_signal, next_out_cont_signal,
        input  out_cont_signal, mem_addr, mem_data, mem_wren
    );
endinterface

// File: rtl/rect_walker.sv
// Emits one pixel coordinate per cycle covering a rectangle, either filled
// (raster order) or as its outline (top, bottom, left, right; no repeats).
module rect_walker #(
    parameter int XW = 8,
    parameter int YW = 8
) (
    input  logic          Clck,
    input  logic          Reset,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic          outline_only,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic          valid,
    output logic          done
);
    logic          active;
    logic          outline_r;
    logic [XW-1:0] x0_r, w_r, cx;
    logic [YW-1:0] y0_r, h_r, cy;
    logic [1:0]    phase;
    logic          last;

    // Outline phases: 0 top row, 1 bottom row, 2 left column, 3 right column.
    always_comb begin
        if (!outline_r)
            last = (cx == w_r - XW'(1)) && (cy == h_r - YW'(1));
        else
            last = (phase == 2'd1 && cx == w_r - XW'(1) && h_r <= YW'(2)) ||
                   (phase == 2'd3 && cy == h_r - YW'(2));
    end

    assign px    = x0_r + cx;
    assign py    = y0_r + cy;
    assign valid = active;
    assign done  = active && last;

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            active    <= 1'b0;
            outline_r <= 1'b0;
            x0_r      <= '0;
            y0_r      <= '0;
            w_r       <= '0;
            h_r       <= '0;
            cx        <= '0;
            cy        <= '0;
            phase     <= 2'd0;
        end else if (start) begin
            active    <= 1'b1;
            outline_r <= outline_only;
            x0_r      <= x0;
            y0_r      <= y0;
            w_r       <= w;
            h_r       <= h;
            cx        <= '0;
            cy        <= '0;
            phase     <= 2'd0;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
            end else if (!outline_r) begin
                if (cx == w_r - XW'(1)) begin
                    cx <= '0;
                    cy <= cy + YW'(1);
                end else begin
                    cx <= cx + XW'(1);
                end
            end else begin
                case (phase)
                    2'd0: if (cx == w_r - XW'(1)) begin
                              phase <= 2'd1;
                              cx    <= '0;
                              cy    <= h_r - YW'(1);
                          end else cx <= cx + XW'(1);
                    2'd1: if (cx == w_r - XW'(1)) begin
                              phase <= 2'd2;
                              cx    <= '0;
                              cy    <= YW'(1);
                          end else cx <= cx + XW'(1);
                    2'd2: if (cy == h_r - YW'(2)) begin
                              phase <= 2'd3;
                              cx    <= w_r - XW'(1);
                              cy    <= YW'(1);
                          end else cy <= cy + YW'(1);
                    default: cy <= cy + YW'(1);
                endcase
            end
        end
    end
endmodule

// File: rtl/board_painter.sv
// Repaints the whole board into external video RAM: background, occupied
// cells, then the cursor outline, and hands off via the continuation pair.
module board_painter
    import fivesons_pkg::*;
#(
    parameter int BOARD_W    = 16,
    parameter int BOARD_H    = 16,
    parameter int CELL_PX_W  = 10,
    parameter int CELL_PX_H  = 6,
    parameter int COLOR_BITS = 3,
    parameter int ADDR_BITS  = 14
) (
    input  logic                                          Clck,
    input  logic                                          Reset,
    board_painter_if.master                               bus,
    input  logic [BOARD_W*BOARD_H*2-1:0]                  board,
    input  logic [1:0]                                    winning_information,
    input  logic [$clog2(BOARD_H)+$clog2(BOARD_W)-1:0]    pointer_loc
);
    localparam int SCR_W = BOARD_W * CELL_PX_W;
    localparam int SCR_H = BOARD_H * CELL_PX_H;
    localparam int XW    = $clog2(SCR_W + 1);
    localparam int YW    = $clog2(SCR_H + 1);
    localparam int AW    = XW + YW;
    localparam int PXW   = $clog2(BOARD_W);
    localparam int PYW   = $clog2(BOARD_H);
    localparam int IDXW  = $clog2(BOARD_W * BOARD_H) + 1;

    state_t                      state, state_nx;
    logic [BOARD_W*BOARD_H*2-1:0] board_r;
    logic [1:0]                  win_r;
    logic [PXW-1:0]              ptr_x_r, ptr_x_in, cell_x;
    logic [PYW-1:0]              ptr_y_r, ptr_y_in, cell_y;
    logic [2:0]                  color_r, color_nx;
    logic                        capture, cell_step, go_ptr, cell_last;
    logic [IDXW-1:0]             cell_idx;
    logic [1:0]                  cur_status;

    logic                        wk_start, wk_outline, wk_valid, wk_done;
    logic [XW-1:0]               wk_x0, wk_w, wk_px;
    logic [YW-1:0]               wk_y0, wk_h, wk_py;
    logic [AW-1:0]               pix_lin;

    // Out-of-range cursor coordinates snap to the last column / row.
    if (2**PXW > BOARD_W) begin : g_clamp_x
        assign ptr_x_in = (pointer_loc[PXW-1:0] > PXW'(BOARD_W-1)) ? PXW'(BOARD_W-1)
                                                                   : pointer_loc[PXW-1:0];
    end else begin : g_pass_x
        assign ptr_x_in = pointer_loc[PXW-1:0];
    end
    if (2**PYW > BOARD_H) begin : g_clamp_y
        assign ptr_y_in = (pointer_loc[PXW+PYW-1:PXW] > PYW'(BOARD_H-1)) ? PYW'(BOARD_H-1)
                                                                         : pointer_loc[PXW+PYW-1:PXW];
    end else begin : g_pass_y
        assign ptr_y_in = pointer_loc[PXW+PYW-1:PXW];
    end

    assign cell_idx   = IDXW'(cell_y) * IDXW'(BOARD_W) + IDXW'(cell_x);
    assign cur_status = 2'(board_r >> {cell_idx, 1'b0});
    assign cell_last  = (cell_x == PXW'(BOARD_W-1)) && (cell_y == PYW'(BOARD_H-1));
    assign pix_lin    = AW'(wk_py) * AW'(SCR_W) + AW'(wk_px);

    rect_walker #(.XW(XW), .YW(YW)) u_walker (
        .Clck         (Clck),
        .Reset        (Reset),
        .start        (wk_start),
        .x0           (wk_x0),
        .y0           (wk_y0),
        .w            (wk_w),
        .h            (wk_h),
        .outline_only (wk_outline),
        .px           (wk_px),
        .py           (wk_py),
        .valid        (wk_valid),
        .done         (wk_done)
    );

    always_ff @(posedge Clck) begin
        if (!Reset) begin
            state   <= ST_IDLE;
            board_r <= '0;
            win_r   <= '0;
            ptr_x_r <= '0;
            ptr_y_r <= '0;
            cell_x  <= '0;
            cell_y  <= '0;
            color_r <= '0;
        end else begin
            state <= state_nx;
            if (wk_start)
                color_r <= color_nx;
            if (capture) begin
                board_r <= board;
                win_r   <= winning_information;
                ptr_x_r <= ptr_x_in;
                ptr_y_r <= ptr_y_in;
                cell_x  <= '0;
                cell_y  <= '0;
            end else if (cell_step) begin
                if (cell_x == PXW'(BOARD_W-1)) begin
                    cell_x <= '0;
                    cell_y <= cell_y + PYW'(1);
                end else begin
                    cell_x <= cell_x + PXW'(1);
                end
            end
        end
    end

    // Every walker launch coincides with the state change, so writes follow back to back.
    always_comb begin
        state_nx   = state;
        wk_start   = 1'b0;
        wk_outline = 1'b0;
        wk_x0      = '0;
        wk_y0      = '0;
        wk_w       = '0;
        wk_h       = '0;
        color_nx   = COL_BG;
        capture    = 1'b0;
        cell_step  = 1'b0;
        go_ptr     = 1'b0;
        case (state)
            ST_IDLE: if (bus.in_cont_signal) begin
                state_nx = ST_BG_FILL;
                capture  = 1'b1;
                wk_start = 1'b1;
                wk_w     = XW'(SCR_W);
                wk_h     = YW'(SCR_H);
            end
            ST_BG_FILL: if (wk_done) state_nx = ST_CELL_SCAN;
            ST_CELL_SCAN: begin
                if (cur_status != CELL_NONE) begin
                    state_nx = ST_CELL_FILL;
                    wk_start = 1'b1;
                    wk_x0    = XW'(cell_x) * XW'(CELL_PX_W);
                    wk_y0    = YW'(cell_y) * YW'(CELL_PX_H);
                    wk_w     = XW'(CELL_PX_W);
                    wk_h     = YW'(CELL_PX_H);
                    color_nx = cell_color(cur_status, win_r);
                end else if (cell_last) begin
                    go_ptr = 1'b1;
                end else begin
                    cell_step = 1'b1;
                end
            end
            ST_CELL_FILL: if (wk_done) begin
                if (cell_last) begin
                    go_ptr = 1'b1;
                end else begin
                    state_nx  = ST_CELL_SCAN;
                    cell_step = 1'b1;
                end
            end
            ST_PTR_DRAW: if (wk_done) state_nx = ST_DONE;
            ST_DONE: if (bus.next_out_cont_signal) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (go_ptr) begin
            state_nx   = ST_PTR_DRAW;
            wk_start   = 1'b1;
            wk_outline = 1'b1;
            wk_x0      = XW'(ptr_x_r) * XW'(CELL_PX_W);
            wk_y0      = YW'(ptr_y_r) * YW'(CELL_PX_H);
            wk_w       = XW'(CELL_PX_W);
            wk_h       = YW'(CELL_PX_H);
            color_nx   = COL_PTR;
        end
    end

    always_comb begin
        bus.out_cont_signal = (state == ST_DONE);
        bus.mem_wren        = wk_valid;
        bus.mem_addr        = wk_valid ? ADDR_BITS'(pix_lin) : '0;
        bus.mem_data        = wk_valid ? COLOR_BITS'(color_r) : '0;
    end
endmodule

// File: tb/tb_board_painter.sv
// Bench for board_painter on a 4x4 board of 2x2-pixel cells (8x8 screen).
module tb_board_painter;
    localparam int BW = 4, BH = 4, CW = 2, CH = 2;
    localparam int SW = BW * CW, SH = BH * CH;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] board;
    logic [1:0]  win;
    logic [3:0]  ptr;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;

    board_painter_if #(.ADDR_BITS(14), .COLOR_BITS(3)) bus ();

    board_painter #(
        .BOARD_W(BW), .BOARD_H(BH), .CELL_PX_W(CW), .CELL_PX_H(CH),
        .COLOR_BITS(3), .ADDR_BITS(14)
    ) dut (
        .Clck                (clk),
        .Reset               (rst_n),
        .bus                 (bus),
        .board               (board),
        .winning_information (win),
        .pointer_loc         (ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int cell_col(input int s, input logic [1:0] w);
        if (s == 1) return 0;
        if (s == 2) return 2;
        return (w == 2'd2 || w == 2'd3) ? 6 : 0;
    endfunction

    function automatic void push_px(input int x, input int y, input int c);
        exp_q.push_back('{addr: x + y * SW, data: c});
    endfunction

    function automatic int status_of(input logic [31:0] b, input int cx, input int cy);
        return int'(2'(b >> (2 * (cy * BW + cx))));
    endfunction

    function automatic int count_occ(input logic [31:0] b);
        int n = 0;
        for (int cy = 0; cy < BH; cy++)
            for (int cx = 0; cx < BW; cx++)
                if (status_of(b, cx, cy) != 0) n++;
        return n;
    endfunction

    // Expected write stream of one frame, straight from the drawing rules.
    function automatic void push_frame(input logic [31:0] b, input logic [1:0] w, input logic [3:0] p);
        int x, y, ox, oy;
        for (int a = 0; a < SW * SH; a++) exp_q.push_back('{addr: a, data: 1});
        for (int cy = 0; cy < BH; cy++)
            for (int cx = 0; cx < BW; cx++)
                if (status_of(b, cx, cy) != 0)
                    for (int yy = 0; yy < CH; yy++)
                        for (int xx = 0; xx < CW; xx++)
                            push_px(cx * CW + xx, cy * CH + yy, cell_col(status_of(b, cx, cy), w));
        x = int'(p[1:0]);
        y = int'(p[3:2]);
        if (x > BW - 1) x = BW - 1;
        if (y > BH - 1) y = BH - 1;
        ox = x * CW;
        oy = y * CH;
        for (int xx = 0; xx < CW; xx++) push_px(ox + xx, oy, 7);
        for (int xx = 0; xx < CW; xx++) push_px(ox + xx, oy + CH - 1, 7);
        for (int yy = 1; yy < CH - 1; yy++) push_px(ox, oy + yy, 7);
        for (int yy = 1; yy < CH - 1; yy++) push_px(ox + CW - 1, oy + yy, 7);
    endfunction

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge clk);
            if (mon_en && bus.mem_wren) begin
                if (exp_q.size() == 0) begin
                    chk("extra_write_addr", int'(bus.mem_addr), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(bus.mem_addr), e.addr);
                    chk("wr_data", int'(bus.mem_data), e.data);
                end
            end
        end
    endtask

    task automatic start(input logic [31:0] b, input logic [1:0] w, input logic [3:0] p);
        board = b;
        win   = w;
        ptr   = p;
        push_frame(b, w, p);
        bus.in_cont_signal = 1'b1;
    endtask

    // Called at a negedge with in_cont already high; the next posedge starts the frame.
    task automatic frame(input int k, input bit pulse_mid, input bit chain);
        int cyc;
        @(posedge clk);
        #1 bus.in_cont_signal = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!bus.out_cont_signal && cyc < 2000) begin
            bus.in_cont_signal = pulse_mid && (cyc == 70);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        chk("frame_len", cyc, SW * SH + BW * BH + CW * CH * k + 2 * (CW + CH) - 4);
        chk("writes_left", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("done_hold", int'(bus.out_cont_signal), 1);
        end
        bus.next_out_cont_signal = 1'b1;
        bus.in_cont_signal       = chain;
        @(negedge clk);
        chk("done_release", int'(bus.out_cont_signal), 0);
        bus.next_out_cont_signal = 1'b0;
    endtask

    task automatic reset_abort();
        int found = 0;
        start(32'h0, 2'd0, 4'h0);
        @(posedge clk);
        #1 bus.in_cont_signal = 1'b0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            #1;
            if (bus.mem_wren && int'(bus.mem_addr) == 30) found = 1;
        end
        chk("reach_addr30", found, 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("abort_wren", int'(bus.mem_wren), 0);
        chk("abort_out", int'(bus.out_cont_signal), 0);
        chk("abort_addr", int'(bus.mem_addr), 0);
        chk("abort_data", int'(bus.mem_data), 0);
        exp_q.delete();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_resume_wren", int'(bus.mem_wren), 0);
        start(32'h0, 2'd0, 4'h0);
        frame(0, 1'b0, 1'b0);
    endtask

    initial begin
        int          pa[4];
        logic [31:0] b;
        logic [1:0]  s;
        rst_n = 1'b0;
        board = '0;
        win   = '0;
        ptr   = '0;
        bus.in_cont_signal       = 1'b0;
        bus.next_out_cont_signal = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", int'(bus.out_cont_signal), 0);
        chk("reset_wren", int'(bus.mem_wren), 0);
        chk("reset_addr", int'(bus.mem_addr), 0);
        chk("reset_data", int'(bus.mem_data), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Empty board, cursor at cell (0,0).
        start(32'h0, 2'd0, 4'h0);
        pa = '{0, 1, 8, 9};
        chk("pin_empty_len", exp_q.size(), 68);
        for (int i = 0; i < 4; i++) begin
            chk("pin_ptr_addr", exp_q[64 + i].addr, pa[i]);
            chk("pin_ptr_data", exp_q[64 + i].data, 7);
        end
        frame(0, 1'b0, 1'b0);

        // Black stone at (3,3).
        start(32'h4000_0000, 2'd0, 4'h0);
        pa = '{54, 55, 62, 63};
        for (int i = 0; i < 4; i++) begin
            chk("pin_black_addr", exp_q[64 + i].addr, pa[i]);
            chk("pin_black_data", exp_q[64 + i].data, 0);
        end
        frame(1, 1'b0, 1'b0);

        // Win cell at (1,0), blue has won, then still gaming.
        start(32'h0000_000C, 2'd3, 4'h0);
        pa = '{2, 3, 10, 11};
        for (int i = 0; i < 4; i++) begin
            chk("pin_win_addr", exp_q[64 + i].addr, pa[i]);
            chk("pin_win_data", exp_q[64 + i].data, 6);
        end
        frame(1, 1'b0, 1'b0);
        start(32'h0000_000C, 2'd0, 4'h0);
        for (int i = 0; i < 4; i++) chk("pin_gaming_data", exp_q[64 + i].data, 0);
        frame(1, 1'b0, 1'b0);

        // Start request pulsed mid-scan must be ignored.
        start(32'h4000_0000, 2'd2, 4'h5);
        frame(1, 1'b1, 1'b0);

        // in_cont held high across DONE chains straight into another frame.
        start(32'h0000_0C09, 2'd2, 4'hF);
        frame(count_occ(board), 1'b0, 1'b1);
        push_frame(board, win, ptr);
        frame(count_occ(board), 1'b0, 1'b0);

        for (int n = 0; n < 4; n++) begin
            b = '0;
            for (int i = 0; i < BW * BH; i++) begin
                s = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
                b = b | (32'(s) << (2 * i));
            end
            start(b, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            frame(count_occ(b), 1'b0, 1'b0);
        end

        reset_abort();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
